// File: rtl/sub_byte_iter_pkg.sv
// -----------------------------------------------------------------------------
// sub_byte_iter_pkg
// Shared AES definitions for the iterative SubBytes engine:
//   state_t          - engine FSM states (IDLE, BUSY, DONE)
//   AES_STATE_BYTES  - bytes in one 128-bit AES state
//   state_byte()     - byte n of a 128-bit word (byte n = w[8n+7:8n])
// -----------------------------------------------------------------------------
package sub_byte_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int AES_STATE_BYTES = 16;

    function automatic logic [7:0] state_byte(input logic [127:0] w, input int n);
        return w[8*n +: 8];
    endfunction

endpackage

// File: rtl/sub_byte_iter_sbox.sv
// -----------------------------------------------------------------------------
// sbox
// Forward AES S-box, combinational. Same port list as inv_sbox.
//   x      in   4  low nibble of the input byte
//   y      in   4  high nibble of the input byte
//   sbout  out  8  S({y,x})
// Computed as the GF(2^8) multiplicative inverse (a^254, with 0 -> 0)
// followed by the AES affine transform, so no 256-entry table is needed.
// -----------------------------------------------------------------------------
module sbox (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] sbout
);

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // a^254 is the inverse for a != 0 and yields 0 for a == 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        logic [7:0] e;
        r  = 8'h01;
        sq = a;
        e  = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    logic [7:0] inv_byte;

    always_comb begin
        inv_byte = gf_inv({y, x});
        sbout    = inv_byte
                 ^ {inv_byte[6:0], inv_byte[7]}
                 ^ {inv_byte[5:0], inv_byte[7:6]}
                 ^ {inv_byte[4:0], inv_byte[7:5]}
                 ^ {inv_byte[3:0], inv_byte[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: rtl/sub_byte_iter.sv
// -----------------------------------------------------------------------------
// sub_byte_iter
// Iterative AES SubBytes: accepts one 128-bit state, substitutes LANES bytes
// per cycle through LANES shared S-boxes, then presents the result.
//   clk_i    in   1    clock
//   rst_n_i  in   1    asynchronous active-low reset
//   valid_i  in   1    data_i holds a state   (accepted only in IDLE)
//   ready_o  out  1    engine is IDLE
//   data_i   in   128  input state, byte n = data_i[8n+7:8n]
//   valid_o  out  1    data_o holds a finished result (DONE)
//   ready_i  in   1    consumer takes the result
//   data_o   out  128  working register, valid only while valid_o=1
//   inv_i    in   1    only with SUB_BYTE_INV_EN: 1 = inverse S-box
// Optional feature macro: SUB_BYTE_INV_EN (adds inv_i, the mode flop and an
// inv_sbox per lane).
// -----------------------------------------------------------------------------
module sub_byte_iter
    import sub_byte_iter_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
`ifdef SUB_BYTE_INV_EN
    input  logic         inv_i,
`endif
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    localparam int CHUNKS = AES_STATE_BYTES / LANES;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [127:0]    work_reg;
    logic [7:0]      lane_in  [LANES];
    logic [7:0]      lane_out [LANES];
    logic            last_chunk;

    assign last_chunk = (cnt_reg == CW'(CHUNKS - 1));

`ifdef SUB_BYTE_INV_EN
    logic mode_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_reg <= 1'b0;
        end else if (state_reg == IDLE && valid_i) begin
            mode_reg <= inv_i;
        end
    end
`endif

    // Lane gi works on byte cnt*LANES+gi of the working register
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] fwd_out;

        assign lane_in[gi] = state_byte(work_reg, int'(cnt_reg) * LANES + gi);

        sbox u_sbox (
            .x     (lane_in[gi][3:0]),
            .y     (lane_in[gi][7:4]),
            .sbout (fwd_out)
        );

`ifdef SUB_BYTE_INV_EN
        logic [7:0] inv_out;

        inv_sbox u_inv_sbox (
            .x     (lane_in[gi][3:0]),
            .y     (lane_in[gi][7:4]),
            .sbout (inv_out)
        );

        assign lane_out[gi] = mode_reg ? inv_out : fwd_out;
`else
        assign lane_out[gi] = fwd_out;
`endif
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_i)    state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (ready_i)    state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            work_reg  <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        work_reg <= data_i;
                        cnt_reg  <= '0;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) begin
                        work_reg[8*(int'(cnt_reg) * LANES + l) +: 8] <= lane_out[l];
                    end
                    // Wrap on the last chunk so the lane index never
                    // points past byte 15 while waiting in DONE.
                    cnt_reg <= last_chunk ? '0 : cnt_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are decoded from the state flops only
    assign ready_o = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);
    assign data_o  = work_reg;

endmodule

// File: tb/tb_sub_byte_iter.sv
// -----------------------------------------------------------------------------
// tb_sub_byte_iter
// Bench for sub_byte_iter with three instances: LANES=4 (index 0),
// LANES=1 (index 1) and LANES=16 (index 2). Expected results come from a
// table built at start-up from the S-box definition (brute-force GF(2^8)
// inverse plus affine transform). Honours SUB_BYTE_INV_EN when defined.
// -----------------------------------------------------------------------------
module tb_sub_byte_iter;

    logic         clk;
    logic         rst_n;
    logic [127:0] data_i;
    logic         inv;
    logic [2:0]   vin;
    logic [2:0]   rin;
    logic [2:0]   rout;
    logic [2:0]   vout;
    logic [127:0] dout [3];

    int total;
    int bad;

    logic [7:0] sb_tab [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sub_byte_iter #(.LANES(4)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(vin[0]), .ready_o(rout[0]),
        .data_i(data_i),
`ifdef SUB_BYTE_INV_EN
        .inv_i(inv),
`endif
        .valid_o(vout[0]), .ready_i(rin[0]), .data_o(dout[0])
    );

    sub_byte_iter #(.LANES(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(vin[1]), .ready_o(rout[1]),
        .data_i(data_i),
`ifdef SUB_BYTE_INV_EN
        .inv_i(inv),
`endif
        .valid_o(vout[1]), .ready_i(rin[1]), .data_o(dout[1])
    );

    sub_byte_iter #(.LANES(16)) dut16 (
        .clk_i(clk), .rst_n_i(rst_n), .valid_i(vin[2]), .ready_o(rout[2]),
        .data_i(data_i),
`ifdef SUB_BYTE_INV_EN
        .inv_i(inv),
`endif
        .valid_o(vout[2]), .ready_i(rin[2]), .data_o(dout[2])
    );

    // ---------------- reference model ----------------
    // Carry-less product then reduction by the AES polynomial 0x11b
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        logic [14:0] poly;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--) begin
            poly = 15'h11b << (i - 8);
            if (p[i]) p = p ^ poly;
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] b;
        logic [7:0] c;
        logic [7:0] s;
        b = 8'h00;
        for (int v = 1; v < 256; v++)
            if (a != 8'h00 && ref_mul(a, 8'(v)) == 8'h01) b = 8'(v);
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [7:0] ref_inv_sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int v = 0; v < 256; v++)
            if (sb_tab[v] == a) r = 8'(v);
        return r;
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] d, input logic use_inv);
        logic [127:0] r;
        for (int n = 0; n < 16; n++)
            r[8*n +: 8] = use_inv ? ref_inv_sbox(d[8*n +: 8]) : sb_tab[d[8*n +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Caller is #1 after a rising edge with instance w idle and ready_i=1.
    task automatic run(input int w, input logic [127:0] d, input int lat,
                       input logic [127:0] exp, input string tag);
        int n;
        data_i = d;
        vin[w] = 1'b1;
        @(posedge clk); #1;
        vin[w] = 1'b0;
        data_i = rand128();   // must not disturb the captured state
        check({tag, " busy_ready"}, 128'(rout[w]), 128'(0));
        n = 0;
        while (!vout[w] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " data"}, dout[w], exp);
        $display("txn %s lanes_idx=%0d in=%h out=%h edges=%0d", tag, w, d, dout[w], n);
        @(posedge clk); #1;
        check({tag, " back_idle"}, {126'(0), rout[w], vout[w]}, 128'(2'b10));
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] held;
        int           n;
        logic         saw_valid;

        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        vin    = '0;
        rin    = '1;
        inv    = 1'b0;
        data_i = '0;
        for (int v = 0; v < 256; v++) sb_tab[v] = ref_sbox(8'(v));

        // Reset state
        #12;
        check("reset ready_o", 128'(rout), 128'(3'b111));
        check("reset valid_o", 128'(vout), 128'(0));
        check("reset data_o", dout[0], 128'h0);
        check("reset data_o lanes16", dout[2], 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors
        run(0, 128'h0, 4, 128'h63636363636363636363636363636363, "zero");
        run(0, 128'h0f0e0d0c0b0a09080706050403020100, 4,
            128'h76abd7fe2b670130c56f6bf27b777c63, "byte_order");
        run(1, {16{8'hff}}, 16, {16{8'h16}}, "ff_lanes1");
        run(2, {16{8'hff}}, 1, {16{8'h16}}, "ff_lanes16");

        // Random states against the model
        for (int i = 0; i < 10; i++) begin
            d = rand128();
            run(0, d, 4, ref_state(d, 1'b0), "rand_lanes4");
        end
        for (int i = 0; i < 3; i++) begin
            d = rand128();
            run(1, d, 16, ref_state(d, 1'b0), "rand_lanes1");
            d = rand128();
            run(2, d, 1, ref_state(d, 1'b0), "rand_lanes16");
        end

        // Backpressure: result held for 5 cycles, new offers ignored
        d      = rand128();
        rin[0] = 1'b0;
        data_i = d;
        vin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        n = 0;
        while (!vout[0] && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp latency", 128'(n), 128'(4));
        check("bp data", dout[0], ref_state(d, 1'b0));
        held = dout[0];
        for (int k = 0; k < 5; k++) begin
            data_i = rand128();
            vin[0] = 1'b1;
            check("bp ready_o low", 128'(rout[0]), 128'(0));
            @(posedge clk); #1;
            check("bp valid_o held", 128'(vout[0]), 128'(1));
            check("bp data_o held", dout[0], held);
        end
        // Offer still present in the consuming cycle: must not be taken
        rin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        check("bp release idle", {126'(0), rout[0], vout[0]}, 128'(2'b10));
        @(posedge clk); #1;
        check("bp no capture on consume", {127'(0), rout[0]}, 128'(1));
        check("bp data unchanged", dout[0], held);
        $display("txn backpressure in=%h out=%h", d, held);

        // Reset mid-BUSY: partial result dropped, no valid afterwards
        data_i = rand128();
        vin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async data_o", dout[0], 128'h0);
        check("rst async flags", {126'(0), rout[0], vout[0]}, 128'(2'b10));
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (vout[0]) saw_valid = 1'b1;
        end
        check("rst no result after release", 128'(saw_valid), 128'(0));
        check("rst data stays zero", dout[0], 128'h0);
        $display("txn reset_mid_busy saw_valid=%0d", saw_valid);

        // First valid after reset is accepted
        d = rand128();
        run(0, d, 4, ref_state(d, 1'b0), "after_reset");

`ifdef SUB_BYTE_INV_EN
        inv = 1'b1;
        run(0, {16{8'h63}}, 4, 128'h0, "inv_63");
        d = rand128();
        run(2, d, 1, ref_state(d, 1'b1), "inv_rand_lanes16");
        // Mode captured at accept; toggling during BUSY has no effect
        d      = rand128();
        inv    = 1'b0;
        data_i = d;
        vin[0] = 1'b1;
        @(posedge clk); #1;
        vin[0] = 1'b0;
        n = 0;
        while (!vout[0] && n < 64) begin
            inv = ~inv;
            @(posedge clk); #1;
            n++;
        end
        check("inv toggle latency", 128'(n), 128'(4));
        check("inv toggle data", dout[0], ref_state(d, 1'b0));
        $display("txn inv_toggle in=%h out=%h", d, dout[0]);
        @(posedge clk); #1;
        inv = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
